// File: rtl/id_ex_stage_if.sv
// Decode/execute stage bus: decode side, register-file read data, write-back
// snoop and the execute-side handshake, grouped so the stage takes one port.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   rf_rd2;
  logic [XLEN-1:0]   id_imm;
  logic [4:0]        id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   ex_rs1_val;
  logic [XLEN-1:0]   ex_rs2_val;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;

  // stage side
  modport slave (
    input  flush, id_valid, id_rs1, id_rs2, rf_rd1, rf_rd2, id_imm, id_rd, id_ctrl,
    input  wb_we, wb_addr, wb_data, ex_ready,
    output id_ready, ex_valid, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_ctrl
  );

  // decode / execute / write-back side
  modport master (
    output flush, id_valid, id_rs1, id_rs2, rf_rd1, rf_rd2, id_imm, id_rd, id_ctrl,
    output wb_we, wb_addr, wb_data, ex_ready,
    input  id_ready, ex_valid, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline stage: captures register operands with write-back bypass and
// hands them to EX through a 2-entry skid buffer (HEAD drives EX, SKID overflow).
// Held operands keep tracking later register-file writes until they are consumed.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input logic         clk,
  input logic         rst,   // active-low, asynchronous
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t state, state_nx;
  ent_t   head, skid, cap;
  logic   accept, pop;
  logic   ex_valid_c, id_ready_c;
  logic   ld_head_cap, ld_skid_cap, mv_skid;

  // Operand as seen at capture: x0 is hard zero, a same-cycle write wins over RD.
  function automatic logic [XLEN-1:0] byp(input logic [4:0] a, input logic [XLEN-1:0] rf,
                                          input logic we, input logic [4:0] wa,
                                          input logic [XLEN-1:0] wd);
    if (a == 5'd0)            return '0;
    else if (we && wa == a)   return wd;
    else                      return rf;
  endfunction

  // Held entry snooping write-back; writes to x0 never land.
  function automatic ent_t refresh(input ent_t e, input logic we, input logic [4:0] wa,
                                   input logic [XLEN-1:0] wd);
    ent_t r;
    r = e;
    if (we && wa != 5'd0 && wa == e.rs1) r.rs1_val = wd;
    if (we && wa != 5'd0 && wa == e.rs2) r.rs2_val = wd;
    return r;
  endfunction

  // Readiness depends only on the state register, so ex_ready never reaches id_ready.
  assign accept = bus.id_valid && (state != S_FULL) && !bus.flush;
  assign pop    = (state != S_EMPTY) && bus.ex_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_EMPTY;
    else      state <= state_nx;
  end

  // Next-state: flush overrides everything, FULL never accepts
  always_comb begin
    state_nx = state;
    if (bus.flush) state_nx = S_EMPTY;
    else begin
      case (state)
        S_EMPTY: if (accept) state_nx = S_ONE;
        S_ONE: begin
          if (accept && !pop)      state_nx = S_FULL;
          else if (pop && !accept) state_nx = S_EMPTY;
        end
        S_FULL:  if (pop) state_nx = S_ONE;
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  // Outputs and datapath steering decoded from state
  always_comb begin
    ex_valid_c  = (state != S_EMPTY);
    id_ready_c  = (state != S_FULL);
    ld_head_cap = accept && ((state == S_EMPTY) || (state == S_ONE && pop));
    ld_skid_cap = accept && (state == S_ONE) && !pop;
    mv_skid     = pop && (state == S_FULL);
  end

  // Capture image of the incoming instruction
  always_comb begin
    cap         = '0;
    cap.rs1     = bus.id_rs1;
    cap.rs2     = bus.id_rs2;
    cap.rs1_val = byp(bus.id_rs1, bus.rf_rd1, bus.wb_we, bus.wb_addr, bus.wb_data);
    cap.rs2_val = byp(bus.id_rs2, bus.rf_rd2, bus.wb_we, bus.wb_addr, bus.wb_data);
    cap.imm     = bus.id_imm;
    cap.rd      = bus.id_rd;
    cap.ctrl    = bus.id_ctrl;
  end

  // Entry storage; refreshing an entry that is invalid or being popped is harmless
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (ld_head_cap)  head <= cap;
      else if (mv_skid) head <= refresh(skid, bus.wb_we, bus.wb_addr, bus.wb_data);
      else              head <= refresh(head, bus.wb_we, bus.wb_addr, bus.wb_data);
      if (ld_skid_cap)  skid <= cap;
      else              skid <= refresh(skid, bus.wb_we, bus.wb_addr, bus.wb_data);
    end
  end

  assign bus.id_ready   = id_ready_c;
  assign bus.ex_valid   = ex_valid_c;
  assign bus.ex_rs1_val = head.rs1_val;
  assign bus.ex_rs2_val = head.rs2_val;
  assign bus.ex_imm     = head.imm;
  assign bus.ex_rd      = head.rd;
  assign bus.ex_ctrl    = head.ctrl;

endmodule
